// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the data-memory responder.
//   state_t       : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES    : bytes per array word
//   ALIGN_MASK    : byte-offset bits that must be zero for a word access
//   addr_to_index : byte address -> word index relative to a base address
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [1:0]  ALIGN_MASK = 2'b11;

   // The subtraction is done at full 32 bits; a wrapped (below-base) result
   // is caught separately by the caller's Addr >= base comparison.
   function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                 input logic [31:0] base);
      logic [31:0] offset;
      offset = addr - base;
      return offset >> $clog2(WORD_BYTES);
   endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port word RAM: synchronous write, registered synchronous read.
// Contents and read register are intentionally not reset.
// Ports:
//   i_clk   : rising-edge clock
//   i_en    : access enable (read or write)
//   i_we    : 1 = write i_wdata to i_addr, 0 = read i_addr into o_rdata
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data; holds until the next enabled read
// -----------------------------------------------------------------------------
module mem_array #(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          i_clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // Storage array write port and registered read port.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core's data port. A request is sampled on a
// clock edge, held for LATENCY edges, then performed against the word RAM;
// MemReady pulses for one cycle with the result. Misaligned or out-of-range
// accesses leave the RAM untouched and return MemErr=1 with ReadData=0.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   MemReq    : request strobe (sampled in IDLE and RESP only)
//   MemWrite  : 1 = write, 0 = read; sampled with MemReq
//   Addr      : byte address
//   WriteData : store data
//   ReadData  : load data / write echo; holds until the next response
//   MemReady  : one-cycle response pulse
//   MemErr    : access error, qualified by MemReady; holds like ReadData
//   Busy      : high while a request is in flight (WAIT)
// -----------------------------------------------------------------------------
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemErr,
   output logic        Busy
);

   localparam int             AW       = $clog2(DEPTH_WORDS);
   localparam int             CW       = $clog2(LATENCY + 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_capture;
   logic          w_access;

   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic          r_write;

   logic          r_ready;
   logic          r_busy;
   logic          r_err;
   logic [31:0]   r_rd_hold;
   logic          r_sel_arr;

   logic [31:0]   w_index_full;
   logic          w_valid;
   logic [31:0]   w_arr_rdata;

   // Range check on the captured request; Addr < BASE_ADDR is rejected
   // explicitly so a wrapped difference can never alias a valid index.
   assign w_index_full = addr_to_index(r_addr, BASE_ADDR);
   assign w_valid      = ((r_addr[1:0] & ALIGN_MASK) == 2'b00) &&
                         (r_addr >= BASE_ADDR) &&
                         (w_index_full < 32'(DEPTH_WORDS));

   // Next-state, counter and strobe decode for the request FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         IDLE: begin
            if (MemReq) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = CNT_LOAD;
               w_state_nxt = WAIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
               w_access    = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         RESP: begin
            // A request seen in the response cycle is taken immediately.
            if (MemReq) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = CNT_LOAD;
               w_state_nxt = WAIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM state and latency counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Request capture registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr  <= 32'h0000_0000;
         r_wdata <= 32'h0000_0000;
         r_write <= 1'b0;
      end else if (w_capture) begin
         r_addr  <= Addr;
         r_wdata <= WriteData;
         r_write <= MemWrite;
      end
   end

   // Response registers; error and data hold between responses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_rd_hold <= 32'h0000_0000;
         r_sel_arr <= 1'b0;
      end else begin
         r_ready <= w_access;
         r_busy  <= (w_state_nxt == WAIT);
         if (w_access) begin
            r_err     <= ~w_valid;
            r_rd_hold <= (w_valid && r_write) ? r_wdata : 32'h0000_0000;
            r_sel_arr <= w_valid && !r_write;
         end
      end
   end

   // The array's read register only updates on an enabled read, so it
   // already holds the last load data; r_sel_arr picks it for valid reads.
   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem_array (
      .i_clk   (clk),
      .i_en    (w_access && w_valid),
      .i_we    (r_write),
      .i_addr  (w_index_full[AW-1:0]),
      .i_wdata (r_wdata),
      .o_rdata (w_arr_rdata)
   );

   assign ReadData = r_sel_arr ? w_arr_rdata : r_rd_hold;
   assign MemReady = r_ready;
   assign MemErr   = r_err;
   assign Busy     = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Three responder instances: [0] LATENCY=2 base 0, [1] LATENCY=2 base 0x1000,
// [2] LATENCY=1 base 0. Each has a transaction-level model (edge count,
// due edge, associative memory) and a per-cycle compare; directed operations
// also check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic        req   [3];
   logic        we    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic        rdy   [3];
   logic        err   [3];
   logic        busy  [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int          L = (g == 2) ? 1 : 2;
      localparam logic [31:0] B = (g == 1) ? 32'h0000_1000 : 32'h0000_0000;

      data_mem_responder #(
         .DEPTH_WORDS (64),
         .LATENCY     (L),
         .BASE_ADDR   (B)
      ) u_dut (
         .clk       (clk),
         .reset     (rst_n),
         .MemReq    (req[g]),
         .MemWrite  (we[g]),
         .Addr      (addr[g]),
         .WriteData (wdata[g]),
         .ReadData  (rdata[g]),
         .MemReady  (rdy[g]),
         .MemErr    (err[g]),
         .Busy      (busy[g])
      );

      // Transaction model: accept when the edge count has reached the next
      // allowed edge, respond L edges later, next accept one edge after that.
      logic [31:0] mem [int];
      int          e_edge = 0;
      int          e_due  = -1;
      int          e_next = 0;
      logic [31:0] p_addr  = 32'h0;
      logic [31:0] p_wdata = 32'h0;
      logic        p_we    = 1'b0;
      logic        x_rdy   = 1'b0;
      logic        x_busy  = 1'b0;
      logic        x_err   = 1'b0;
      logic [31:0] x_rd    = 32'h0;
      logic        x_known = 1'b1;

      initial begin
         logic [31:0] idx;
         logic        ok;
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
               e_edge = 0; e_due = -1; e_next = 0;
               x_rdy = 1'b0; x_busy = 1'b0; x_err = 1'b0; x_rd = 32'h0; x_known = 1'b1;
            end else begin
               e_edge++;
               x_rdy = 1'b0;
               if (e_edge == e_due) begin
                  idx = (p_addr - B) / 32'd4;
                  ok  = (p_addr % 32'd4 == 32'd0) && (p_addr >= B) && (idx < 32'd64);
                  x_rdy = 1'b1;
                  x_err = !ok;
                  x_known = 1'b1;
                  if (!ok) begin
                     x_rd = 32'h0;
                  end else if (p_we) begin
                     mem[int'(idx)] = p_wdata;
                     x_rd = p_wdata;
                  end else if (mem.exists(int'(idx))) begin
                     x_rd = mem[int'(idx)];
                  end else begin
                     x_known = 1'b0;
                  end
               end
               if (req[g] && e_edge >= e_next) begin
                  p_addr  = addr[g];
                  p_we    = we[g];
                  p_wdata = wdata[g];
                  e_due   = e_edge + L;
                  e_next  = e_edge + L + 1;
               end
               x_busy = (e_due > e_edge);
            end
         end
      end

      // Per-cycle compare against the model, away from the active edge.
      initial begin
         #4;
         wait (rst_n == 1'b1);
         forever begin
            @(negedge clk);
            chk($sformatf("i%0d_ready", g), 32'(rdy[g]),  32'(x_rdy));
            chk($sformatf("i%0d_busy", g),  32'(busy[g]), 32'(x_busy));
            chk($sformatf("i%0d_err", g),   32'(err[g]),  32'(x_err));
            if (x_known) chk($sformatf("i%0d_rdata", g), rdata[g], x_rd);
         end
      end
   end

   function automatic int lat_of(input int i);
      return (i == 2) ? 1 : 2;
   endfunction

   // One request, started at a negedge; waits a bounded number of cycles.
   task automatic op(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat, output logic got);
      req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
      @(negedge clk);
      req[i] = 1'b0;
      got = 1'b0; lat = 0; rd = 32'h0; er = 1'b0;
      for (int k = 1; k <= 6 && !got; k++) begin
         @(negedge clk);
         if (rdy[i]) begin
            got = 1'b1; lat = k; rd = rdata[i]; er = err[i];
         end
      end
      @(negedge clk);
   endtask

   task automatic op_expect(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_er, input string nm);
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        got;
      op(i, w, a, d, rd, er, lat, got);
      chk({nm, "_seen"}, 32'(got), 32'd1);
      chk({nm, "_lat"},  32'(lat), 32'(lat_of(i)));
      chk({nm, "_data"}, rd, exp_rd);
      chk({nm, "_err"},  32'(er), 32'(exp_er));
   endtask

   initial begin
      int          pulses;
      logic [31:0] seen [3];

      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
      end
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_rdata", rdata[0], 32'h0);
      chk("reset_ready", 32'(rdy[0]),  32'd0);
      chk("reset_err",   32'(err[0]),  32'd0);
      chk("reset_busy",  32'(busy[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write then read, latency 2.
      op_expect(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "wr_10");
      op_expect(0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd_10");

      // Misaligned read, then the word is unchanged.
      op_expect(0, 1'b0, 32'h13, 32'h0, 32'h0,         1'b1, "rd_mis");
      op_expect(0, 1'b1, 32'h12, 32'h1111_2222, 32'h0, 1'b1, "wr_mis");
      op_expect(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd_10_again");

      // Range boundaries with DEPTH 64: index 63 ok, index 64 rejected.
      op_expect(0, 1'b1, 32'h100, 32'h0BAD_0BAD, 32'h0,         1'b1, "wr_100");
      op_expect(0, 1'b1, 32'hFC,  32'h600D_F00D, 32'h600D_F00D, 1'b0, "wr_fc");
      op_expect(0, 1'b0, 32'hFC,  32'h0,         32'h600D_F00D, 1'b0, "rd_fc");

      // Non-zero base.
      op_expect(1, 1'b0, 32'h0FFC, 32'h0, 32'h0, 1'b1, "b_rd_ffc");
      op_expect(1, 1'b0, 32'h0000, 32'h0, 32'h0, 1'b1, "b_rd_0");
      op_expect(1, 1'b1, 32'h1000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "b_wr_1000");
      op_expect(1, 1'b0, 32'h1000, 32'h0,         32'hCAFE_F00D, 1'b0, "b_rd_1000");
      op_expect(1, 1'b1, 32'h1100, 32'h1, 32'h0, 1'b1, "b_wr_1100");

      // Back-to-back with MemReq held high: accepts at E0, E0+3, E0+6.
      op_expect(0, 1'b1, 32'h0, 32'h0000_0A0A, 32'h0000_0A0A, 1'b0, "pre_0");
      op_expect(0, 1'b1, 32'h4, 32'h0000_0B0B, 32'h0000_0B0B, 1'b0, "pre_4");
      pulses = 0;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         if (k == 0) addr[0] = 32'h4;
         if (k == 3) addr[0] = 32'h0;
         if (rdy[0]) begin
            if (pulses < 3) seen[pulses] = rdata[0];
            pulses++;
         end
      end
      req[0] = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd3);
      chk("b2b_data0", seen[0], 32'h0000_0A0A);
      chk("b2b_data1", seen[1], 32'h0000_0B0B);
      chk("b2b_data2", seen[2], 32'h0000_0A0A);
      repeat (2) @(negedge clk);

      // Reset during WAIT of a write: dropped, outputs clear at once.
      op_expect(0, 1'b1, 32'h20, 32'h11, 32'h11, 1'b0, "pre_20");
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
      @(negedge clk);
      req[0] = 1'b0;
      chk("wait_busy", 32'(busy[0]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_rdata", rdata[0], 32'h0);
      chk("rst_mid_ready", 32'(rdy[0]),  32'd0);
      chk("rst_mid_err",   32'(err[0]),  32'd0);
      chk("rst_mid_busy",  32'(busy[0]), 32'd0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (rdy[0]) pulses++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rdy[0]) pulses++;
      end
      chk("rst_mid_pulses", 32'(pulses), 32'd0);
      op_expect(0, 1'b0, 32'h20, 32'h0, 32'h11, 1'b0, "rd_20_after_rst");

      // Latency 1 sweep: alternating write/read over 8 words.
      for (int j = 0; j < 8; j++) begin
         op_expect(2, 1'b1, 32'h40 + 32'(j) * 32'd4, 32'hA5A5_0000 + 32'(j),
                   32'hA5A5_0000 + 32'(j), 1'b0, $sformatf("l1_wr%0d", j));
         op_expect(2, 1'b0, 32'h40 + 32'(j) * 32'd4, 32'h0,
                   32'hA5A5_0000 + 32'(j), 1'b0, $sformatf("l1_rd%0d", j));
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
